// File: rtl/fp_vec_accel.sv
// In-place FP32 vector engine: square, scale-by-COEF or copy over DEPTH words.
// Define FP_VEC_ACCEL_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_vec_accel #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        bsy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   coef_run_q, coef_run_d;
  logic          s1_vld_q, s1_vld_d;
  logic [AW-1:0] s1_idx_q, s1_idx_d;
  logic [31:0]   s1_x_q, s1_x_d;
  logic [31:0]   dout_q, dout_d;
  logic          done_q, done_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] coef_q;

  logic          hit_word, hit_coef, host_we, wb_en;
  logic [AW-1:0] idx;
  logic [31:0]   f_res;
  logic          unused_addr;

  assign unused_addr = ^addr[1:0];
  assign idx      = addr[AW+1:2];
  assign hit_word = (addr[31:AW+2] == '0);
  assign hit_coef = (addr[31:2] == 30'(DEPTH));
  assign bsy      = (state_q != StIdle);
  assign host_we  = wen & ~bsy & ~rst;
  assign wb_en    = s1_vld_q & ~rst;
  assign dout     = dout_q;
  assign done     = done_q;

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sign;
    logic [7:0]        ea, eb;
    logic [47:0]       prod;
    logic [22:0]       mant;
    logic signed [9:0] exp;
    logic [31:0]       res;
`ifdef FP_VEC_ACCEL_ROUND_EN
    logic              guard, sticky, carry;
`endif
    sign = a[31] ^ b[31];
    ea   = a[30:23];
    eb   = b[30:23];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      mant = prod[46:24];
      exp  = exp + 10'sd1;
    end else begin
      mant = prod[45:23];
    end
`ifdef FP_VEC_ACCEL_ROUND_EN
    guard  = prod[47] ? prod[23] : prod[22];
    sticky = prod[47] ? (|prod[22:0]) : (|prod[21:0]);
    carry  = 1'b0;
    if (guard && (sticky || mant[0])) begin
      {carry, mant} = {1'b0, mant} + 24'd1;
    end
    // Mantissa overflow wraps to zero, i.e. 1.0 * 2^(exp+1)
    if (carry) begin
      exp = exp + 10'sd1;
    end
`endif
    if (ea == 8'h00 || eb == 8'h00) begin
      res = {sign, 31'd0};
    end else if (ea == 8'hFF || eb == 8'hFF) begin
      res = {sign, 8'hFF, 23'd0};
    end else if (exp >= 10'sd255) begin
      res = {sign, 8'hFF, 23'd0};
    end else if (exp <= 10'sd0) begin
      res = {sign, 31'd0};
    end else begin
      res = {sign, exp[7:0], mant};
    end
    return res;
  endfunction

  always_comb begin
    unique case (mode_q)
      2'd0:    f_res = fp_mul(s1_x_q, s1_x_q);
      2'd1:    f_res = fp_mul(s1_x_q, coef_run_q);
      default: f_res = s1_x_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    coef_run_d = coef_run_q;
    s1_vld_d   = 1'b0;
    s1_idx_d   = s1_idx_q;
    s1_x_d     = s1_x_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          cnt_d      = '0;
          mode_d     = mode;
          // A COEF write in the same cycle as start must be seen by this run
          coef_run_d = (host_we && hit_coef) ? din : coef_q;
        end
      end
      StRun: begin
        s1_vld_d = 1'b1;
        s1_idx_d = cnt_q;
        s1_x_d   = mem_q[cnt_q];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Gate on next state so dout is already zero in the first busy cycle
    dout_d = '0;
    if (state_d == StIdle) begin
      if (hit_word) begin
        dout_d = mem_q[idx];
      end else if (hit_coef) begin
        dout_d = coef_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mode_q     <= 2'd0;
      coef_run_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_x_q     <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      coef_run_q <= coef_run_d;
      s1_vld_q   <= s1_vld_d;
      s1_idx_q   <= s1_idx_d;
      s1_x_q     <= s1_x_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
    end
  end

  // Storage is intentionally unreset; host writes and write-backs never overlap.
  always_ff @(posedge clk) begin
    if (host_we && hit_word) begin
      mem_q[idx] <= din;
    end
    if (wb_en) begin
      mem_q[s1_idx_q] <= f_res;
    end
    if (host_we && hit_coef) begin
      coef_q <= din;
    end
  end

endmodule

// File: tb/tb_fp_vec_accel.sv
// Directed self-checking bench for fp_vec_accel (DEPTH=16) using immediate assertions.
module tb_fp_vec_accel;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        bsy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  int nb, nd, nal, ndo;

  fp_vec_accel #(.DEPTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .start (start),
    .mode  (mode),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .bsy   (bsy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    wen  = 1'b1;
    @(posedge clk);
    #1 wen = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    @(posedge clk);
    #1 check(tag, dout, exp);
  endtask

  // Launch a run and watch a fixed 40-cycle window; optional poke during busy.
  task automatic run(input logic [1:0] m, input bit poke,
                     output int o_nb, output int o_nd, output int o_nal, output int o_ndo);
    logic prev_bsy;
    o_nb = 0; o_nd = 0; o_nal = 0; o_ndo = 0;
    prev_bsy = 1'b0;
    mode  = m;
    addr  = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bsy) o_nb++;
      if (done) begin
        o_nd++;
        if (!bsy && prev_bsy) o_nal++;
      end
      if (bsy && dout !== 32'd0) o_ndo++;
      prev_bsy = bsy;
      if (poke && c == 3) begin
        wen = 1'b1; addr = 32'd20; din = 32'h12345678; start = 1'b1;
      end else begin
        wen = 1'b0; start = 1'b0; addr = 32'd0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_run(input string tag);
    check({tag, "_bsy_len"}, 32'(nb), 32'd17);
    check({tag, "_done_cnt"}, 32'(nd), 32'd1);
    check({tag, "_done_at_fall"}, 32'(nal), 32'd1);
    check({tag, "_dout_zero_busy"}, 32'(ndo), 32'd0);
  endtask

  initial begin
    logic [31:0] rnd_exp;
    int nd_after;
    rst = 1'b1; wen = 1'b0; start = 1'b0; mode = 2'd0; addr = 32'd0; din = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_bsy", {31'd0, bsy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dout", dout, 32'd0);
    rst = 1'b0;

    // Square mode
    for (int i = 0; i < 16; i++) wr(32'(i * 4), 32'd0);
    wr(32'd0, 32'h3f000000);
    wr(32'd40, 32'h41200000);
    run(2'd0, 1'b0, nb, nd, nal, ndo);
    check_run("sq");
    rd_check("sq_w0", 32'd0, 32'h3e800000);
    rd_check("sq_w10", 32'd40, 32'h42c80000);
    rd_check("sq_w1", 32'd4, 32'h00000000);

    // Scale mode, COEF decode and out-of-range address
    wr(32'd64, 32'h40000000);
    wr(32'd3 * 4, 32'h3fc00000);
    wr(32'd68, 32'hffffffff);
    rd_check("coef_rd", 32'd64, 32'h40000000);
    rd_check("bad_addr_rd", 32'd68, 32'h00000000);
    rd_check("word_addr_lowbits", 32'd15, 32'h3fc00000);
    run(2'd1, 1'b0, nb, nd, nal, ndo);
    check_run("sc");
    rd_check("sc_w3", 32'd12, 32'h40400000);
    rd_check("sc_w0", 32'd0, 32'h3f000000);
    rd_check("sc_w10", 32'd40, 32'h43480000);

    // FP edge cases, rounding, and busy-time write/start
    wr(32'd0, 32'h7f000000);
    wr(32'd4, 32'h00000000);
    wr(32'd8, 32'hbf000000);
    wr(32'd12, 32'h3fc00001);
    wr(32'd20, 32'h40000000);
    run(2'd0, 1'b1, nb, nd, nal, ndo);
    check_run("busy");
    rd_check("edge_ovf", 32'd0, 32'h7f800000);
    rd_check("edge_zero", 32'd4, 32'h00000000);
    rd_check("edge_neg", 32'd8, 32'h3e800000);
`ifdef FP_VEC_ACCEL_ROUND_EN
    rnd_exp = 32'h40100002;
`else
    rnd_exp = 32'h40100001;
`endif
    rd_check("round", 32'd12, rnd_exp);
    rd_check("busy_wen_ignored", 32'd20, 32'h40800000);

    // Copy mode leaves data unchanged
    run(2'd2, 1'b0, nb, nd, nal, ndo);
    check_run("cp");
    rd_check("cp_w0", 32'd0, 32'h7f800000);
    rd_check("cp_w3", 32'd12, rnd_exp);

    // Start and COEF write in the same idle cycle: run must use the new COEF
    addr = 32'd64; din = 32'h40400000; wen = 1'b1; mode = 2'd1; start = 1'b1;
    @(posedge clk);
    #1 wen = 1'b0; start = 1'b0; addr = 32'd0;
    repeat (30) @(posedge clk);
    #1 check("sw_idle", {31'd0, bsy}, 32'd0);
    rd_check("sw_w2", 32'd8, 32'h3f400000);
    rd_check("sw_w0_inf", 32'd0, 32'h7f800000);
    rd_check("sw_coef", 32'd64, 32'h40400000);

    // Reset mid-run
    for (int i = 0; i < 16; i++) wr(32'(i * 4), 32'h40000000);
    mode = 2'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_bsy", {31'd0, bsy}, 32'd0);
    check("mid_rst_dout", dout, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    nd_after = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1 if (done || bsy) nd_after++;
    end
    check("mid_rst_no_done", 32'(nd_after), 32'd0);
    rd_check("mid_rst_w0", 32'd0, 32'h40800000);
    rd_check("mid_rst_w1", 32'd4, 32'h40800000);
    for (int i = 4; i < 16; i++) rd_check($sformatf("mid_rst_w%0d", i), 32'(i * 4), 32'h40000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
